// File: rtl/logic_op_sequencer.sv
// Sequences Z80 AND/OR/XOR/CPL through the external 16-bit logic datapath,
// fetching the operand from (HL) when needed, and issues one A/F writeback.
module logic_op_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  src,
    input  logic [7:0]  operand,
    input  logic [15:0] hl,
    input  logic [7:0]  acc_in,
    input  logic [7:0]  f_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [15:0] lb_a,
    output logic [15:0] lb_b,
    output logic [1:0]  lb_opp,
    input  logic [15:0] lb_out,
    input  logic [7:0]  lb_flags,
    output logic [7:0]  acc_out,
    output logic [7:0]  f_out,
    output logic        acc_we,
    output logic        f_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    // Handshake: mem_rd stays high with a stable mem_addr for every FETCH cycle;
    // a read completes on the first rising edge that samples mem_ack high.

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic [7:0]     fl_q, fl_d;
    logic           take;
    logic           tmo_hit;
    logic [7:0]     merged_f;

    logic [15:0]    mem_addr_q, lb_a_q, lb_b_q;
    logic [1:0]     lb_opp_q;
    logic [7:0]     acc_out_q, f_out_q;
    logic           mem_rd_q, wb_q, busy_q, err_q;

    logic           unused_hi;
    assign unused_hi = ^lb_out[15:8];

    assign take    = (state_q == S_IDLE) && start;
    assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (op == 2'b11)       state_d = S_EXEC;
                    else if (src == 2'b10) state_d = S_FETCH;
                    else if (src == 2'b11) state_d = S_ABORT;
                    else                   state_d = S_EXEC;
                end
            end
            S_FETCH: begin
                if (mem_ack)      state_d = S_EXEC;
                else if (tmo_hit) state_d = S_ABORT;
                else              cnt_d = cnt_q + 1'b1;
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d = take ? op : op_q;
        a_d  = take ? acc_in : a_q;
        fl_d = take ? f_in : fl_q;
        b_d  = b_q;
        if (take)
            b_d = operand;
        else if ((state_q == S_FETCH) && mem_ack)
            b_d = mem_data;
    end

    // CPL keeps S, Z, P and C from the old F; the datapath flags are not used.
    always_comb begin
        merged_f = lb_flags;
        if (op_q == 2'b11)
            merged_f = {fl_q[7], fl_q[6], lb_out[5], 1'b1, lb_out[3], fl_q[2], 1'b1, fl_q[0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 2'b00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            fl_q       <= 8'h00;
            mem_addr_q <= 16'h0000;
            lb_a_q     <= 16'h0000;
            lb_b_q     <= 16'h0000;
            lb_opp_q   <= 2'b00;
            acc_out_q  <= 8'h00;
            f_out_q    <= 8'h00;
            mem_rd_q   <= 1'b0;
            wb_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fl_q     <= fl_d;
            mem_rd_q <= (state_d == S_FETCH);
            wb_q     <= (state_d == S_WB);
            err_q    <= (state_d == S_ABORT);
            busy_q   <= (state_d != S_IDLE);
            if (take && (state_d == S_FETCH))
                mem_addr_q <= hl;
            if (state_d == S_EXEC) begin
                lb_a_q   <= {8'h00, a_d};
                lb_b_q   <= {8'h00, b_d};
                lb_opp_q <= op_d;
            end
            if (state_q == S_EXEC) begin
                acc_out_q <= lb_out[7:0];
                f_out_q   <= merged_f;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign lb_a      = lb_a_q;
    assign lb_b      = lb_b_q;
    assign lb_opp    = lb_opp_q;
    assign acc_out   = acc_out_q;
    assign f_out     = f_out_q;
    assign acc_we    = wb_q;
    assign f_we      = wb_q;
    assign done      = wb_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomized scoreboard bench for logic_op_sequencer with a behavioural datapath
// and memory responder; a negedge monitor pops expected writebacks.
module tb_logic_op_sequencer;

    localparam int T = 4;

    logic        clk, reset, start, mem_rd, mem_ack;
    logic [1:0]  op, src, lb_opp;
    logic [7:0]  operand, acc_in, f_in, mem_data, lb_flags, acc_out, f_out;
    logic [15:0] hl, mem_addr, lb_a, lb_b, lb_out, r16;
    logic        acc_we, f_we, busy, done, err;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    logic_op_sequencer #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src(src),
        .operand(operand), .hl(hl), .acc_in(acc_in), .f_in(f_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
        .lb_a(lb_a), .lb_b(lb_b), .lb_opp(lb_opp), .lb_out(lb_out), .lb_flags(lb_flags),
        .acc_out(acc_out), .f_out(f_out), .acc_we(acc_we), .f_we(f_we),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic datapath stand-in; CPL flags are junk so only the merge can fix them.
    always_comb begin
        r16 = 16'h0000;
        case (lb_opp)
            2'b00: r16 = lb_a & lb_b;
            2'b01: r16 = lb_a | lb_b;
            2'b10: r16 = lb_a ^ lb_b;
            default: r16 = ~lb_a;
        endcase
        lb_out   = r16;
        lb_flags = (lb_opp == 2'b11) ? (8'h5A ^ lb_a[7:0]) :
                   {r16[7], (r16 == 16'h0000), r16[5], (lb_opp == 2'b00), r16[3], ~^r16, 2'b00};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected {err, A, F} from the instruction semantics.
    function automatic logic [16:0] ref_model(input logic [1:0] o, input logic [1:0] s,
                                              input logic [7:0] opd, input logic [7:0] a,
                                              input logic [7:0] fl, input logic [7:0] md,
                                              input int ack_at);
        logic [7:0] b, r, fo;
        logic zf, pf, hf;
        if (o == 2'b11) begin
            r  = 8'hFF - a;
            fo = {fl[7], fl[6], r[5], 1'b1, r[3], fl[2], 1'b1, fl[0]};
            return {1'b0, r, fo};
        end
        if (s == 2'b11) return {1'b1, 16'h0000};
        if (s == 2'b10 && ack_at > T) return {1'b1, 16'h0000};
        b = (s == 2'b10) ? md : opd;
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            default: r = a ^ b;
        endcase
        zf = (r == 8'h00);
        pf = (($countones(r) % 2) == 0);
        hf = (o == 2'b00);
        fo = {r[7], zf, r[5], hf, r[3], pf, 1'b0, 1'b0};
        return {1'b0, r, fo};
    endfunction

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [7:0] opd,
                          input logic [15:0] h, input logic [7:0] a, input logic [7:0] fl,
                          input logic [7:0] md, input int ack_at, input bit glitch);
        bit fetch;
        int exp_rd, exp_lat, cyc, rd, lat;
        bit addr_bad;
        fetch   = (o != 2'b11) && (s == 2'b10);
        exp_rd  = fetch ? ((ack_at <= T) ? ack_at : T) : 0;
        exp_lat = (o != 2'b11 && s == 2'b11) ? 1 :
                  fetch ? ((ack_at <= T) ? ack_at + 2 : T + 1) : 2;
        exp_q.push_back(ref_model(o, s, opd, a, fl, md, ack_at));
        start = 1'b1; op = o; src = s; operand = opd; hl = h; acc_in = a; f_in = fl;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); src = 2'($urandom);
        operand = 8'($urandom); acc_in = 8'($urandom); f_in = 8'($urandom); hl = 16'($urandom);
        cyc = 0; rd = 0; lat = 0; addr_bad = 1'b0;
        while (lat == 0 && cyc < 40) begin
            cyc++;
            if (done || err) begin
                lat = cyc;
            end else begin
                if (mem_rd) begin
                    rd++;
                    if (mem_addr !== h) addr_bad = 1'b1;
                    if (rd == ack_at) begin
                        mem_ack = 1'b1;
                        mem_data = md;
                    end
                end
                if (glitch && cyc == 1) begin
                    start = 1'b1; op = 2'($urandom); src = 2'($urandom);
                    acc_in = 8'($urandom); operand = 8'($urandom);
                end
                @(posedge clk); #1;
                mem_ack = 1'b0; start = 1'b0; mem_data = 8'($urandom);
            end
        end
        check("latency", lat, exp_lat);
        check("rd_cycles", rd, exp_rd);
        if (fetch) check("mem_addr", {31'd0, addr_bad}, 0);
        @(posedge clk); #1;
        check("busy_after", {31'd0, busy}, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctrl"}, {26'd0, mem_rd, acc_we, f_we, done, err, busy}, 0);
        check({tag, "_addr"}, {16'd0, mem_addr}, 0);
        check({tag, "_acc_f"}, {16'd0, acc_out, f_out}, 0);
        check({tag, "_lb"}, {lb_a, lb_b}, 0);
        check({tag, "_opp_state"}, {27'd0, lb_opp, dbg_state}, 0);
    endtask

    initial begin : monitor
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!reset && (done || err || acc_we || f_we)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {28'd0, err, done, acc_we, f_we}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[16]) begin
                        check("abort_strobes", {28'd0, err, done, acc_we, f_we}, 32'h8);
                    end else begin
                        check("wb_strobes", {28'd0, err, done, acc_we, f_we}, 32'h7);
                        check("acc_out", {24'd0, acc_out}, {24'd0, e[15:8]});
                        check("f_out", {24'd0, f_out}, {24'd0, e[7:0]});
                    end
                end
            end
        end
    end

    initial begin : main
        logic [1:0] o, s;
        int ack_at;
        bit gl;
        reset = 1'b1; start = 1'b0; op = 2'b00; src = 2'b00; operand = 8'h00;
        hl = 16'h0000; acc_in = 8'h00; f_in = 8'h00; mem_data = 8'h00; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 2'b00, 8'h0F, 16'h1234, 8'h3C, 8'hFF, 8'h00, 0, 1'b0);
        run_op(2'b10, 2'b01, 8'h5A, 16'h0000, 8'h5A, 8'h00, 8'h00, 0, 1'b0);
        run_op(2'b01, 2'b10, 8'h00, 16'hC000, 8'h01, 8'h00, 8'h80, 3, 1'b0);
        run_op(2'b11, 2'b10, 8'h00, 16'hC000, 8'h28, 8'hC5, 8'h00, 1, 1'b0);
        run_op(2'b00, 2'b10, 8'h00, 16'hBEEF, 8'hFF, 8'h00, 8'h00, 99, 1'b0);
        run_op(2'b01, 2'b10, 8'h00, 16'h4000, 8'h10, 8'h00, 8'h01, T, 1'b0);
        run_op(2'b01, 2'b11, 8'h33, 16'h0000, 8'h10, 8'h00, 8'h00, 0, 1'b0);
        run_op(2'b10, 2'b10, 8'h00, 16'h8001, 8'hF0, 8'h00, 8'h0F, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            o      = 2'($urandom_range(0, 3));
            s      = 2'($urandom_range(0, 3));
            ack_at = $urandom_range(1, 6);
            gl     = (s == 2'b10) && (o != 2'b11) && ($urandom_range(0, 3) == 0);
            run_op(o, s, 8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), ack_at, gl);
        end

        // Reset during the second FETCH cycle abandons the read.
        start = 1'b1; op = 2'b01; src = 2'b10; hl = 16'hA5A5; acc_in = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_fetch_rd", {31'd0, mem_rd}, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outs("midrst");
        mem_ack = 1'b1; mem_data = 8'hFF;
        repeat (2) begin
            @(posedge clk); #1;
            check("late_ack_idle", {29'd0, busy, mem_rd, done}, 0);
        end
        mem_ack = 1'b0;
        run_op(2'b00, 2'b00, 8'hF3, 16'h0000, 8'h3C, 8'h00, 8'h00, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
